// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux channel by channel, samples its output into a 4-bit frame and hands the frame
// downstream over valid/ready. Optional build macro MUX_SCAN_PARITY_EN adds the frame_par_o port.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       cont_i,
  output logic       s1_o,
  output logic       s0_o,
  input  logic       op_in_i,
  output logic [3:0] frame_o,
  output logic       frame_valid_o,
  input  logic       frame_ready_i,
`ifdef MUX_SCAN_PARITY_EN
  output logic       frame_par_o,
`endif
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StOut} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  state_e     state_q;
  logic [1:0] ch_q;
  logic [3:0] cnt_q;
  logic [2:0] shadow_q;
  logic [1:0] sel_q;
  logic [3:0] frame_q;
  logic       frame_valid_q;
  logic       busy_q;
  logic       frame_par_q;

  // Full frame as it will look after the final sampling edge.
  logic [3:0] frame_full;
  assign frame_full = {op_in_i, shadow_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ch_q          <= 2'd0;
      cnt_q         <= 4'd0;
      shadow_q      <= 3'd0;
      sel_q         <= 2'd0;
      frame_q       <= 4'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_par_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSettle;
            ch_q    <= 2'd0;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StSample: begin
          if (ch_q != 2'd3) begin
            shadow_q[ch_q] <= op_in_i;
            ch_q           <= ch_q + 2'd1;
            sel_q          <= ch_q + 2'd1;
            cnt_q          <= 4'd0;
            state_q        <= StSettle;
          end else begin
            frame_q       <= frame_full;
            frame_par_q   <= ^frame_full;
            frame_valid_q <= 1'b1;
            sel_q         <= 2'd0;
            state_q       <= StOut;
          end
        end
        StOut: begin
          // cont_i is only looked at on the transfer edge; a stalled sink freezes the scan here.
          if (frame_ready_i) begin
            frame_valid_q <= 1'b0;
            if (cont_i) begin
              ch_q    <= 2'd0;
              cnt_q   <= 4'd0;
              sel_q   <= 2'd0;
              state_q <= StSettle;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s1_o          = sel_q[1];
  assign s0_o          = sel_q[0];
  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign busy_o        = busy_q;

`ifdef MUX_SCAN_PARITY_EN
  assign frame_par_o = frame_par_q;
`else
  logic unused_par;
  assign unused_par = frame_par_q;
`endif

endmodule
